// File: rtl/serial_adder_if.sv
// Operand/result bundle between a requester and the bit-serial adder.
// The requester drives start/sub/a/b/c_in; the adder drives busy/done/sum/c_out/ovf.
interface serial_adder_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic             sub;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             c_in;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] sum;
    logic             c_out;
    logic             ovf;

    modport master (
        output start, sub, a, b, c_in,
        input  busy, done, sum, c_out, ovf
    );

    modport slave (
        input  start, sub, a, b, c_in,
        output busy, done, sum, c_out, ovf
    );
endinterface

// File: rtl/serial_adder.sv
// Bit-serial add/sub through one full-adder slice; result WIDTH+1 cycles after start.
// No backpressure: start is taken only in IDLE/DONE and silently dropped while busy.
module serial_adder #(
    parameter int WIDTH = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    serial_adder_if.slave bus
);
    localparam int CW = $clog2(WIDTH);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]       state_q, state_d;
    logic [WIDTH-1:0] a_sh_q, a_sh_d;
    logic [WIDTH-1:0] b_sh_q, b_sh_d;
    logic [WIDTH-1:0] r_q, r_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             carry_q, carry_d;
    logic             c_out_q, c_out_d;
    logic             ovf_q, ovf_d;

    logic fa_s;
    logic fa_co;
    logic accept;
    logic last;

    always_comb begin
        fa_s   = a_sh_q[0] ^ b_sh_q[0] ^ carry_q;
        fa_co  = (a_sh_q[0] & b_sh_q[0]) | (carry_q & (a_sh_q[0] ^ b_sh_q[0]));
        accept = bus.start && ((state_q == S_IDLE) || (state_q == S_DONE));
        last   = (cnt_q == CW'(WIDTH - 1));

        state_d = state_q;
        a_sh_d  = a_sh_q;
        b_sh_d  = b_sh_q;
        r_d     = r_q;
        sum_d   = sum_q;
        cnt_d   = cnt_q;
        carry_d = carry_q;
        c_out_d = c_out_q;
        ovf_d   = ovf_q;

        case (state_q)
            S_IDLE, S_DONE: begin
                if (accept) begin
                    // Subtraction is a + ~b + 1: invert B and force the carry-in.
                    a_sh_d  = bus.a;
                    b_sh_d  = bus.sub ? ~bus.b : bus.b;
                    carry_d = bus.sub ? 1'b1 : bus.c_in;
                    r_d     = '0;
                    cnt_d   = '0;
                    state_d = S_RUN;
                end else if (state_q == S_DONE) begin
                    state_d = S_IDLE;
                end
            end
            S_RUN: begin
                r_d     = {fa_s, r_q[WIDTH-1:1]};
                a_sh_d  = {1'b0, a_sh_q[WIDTH-1:1]};
                b_sh_d  = {1'b0, b_sh_q[WIDTH-1:1]};
                carry_d = fa_co;
                cnt_d   = cnt_q + CW'(1);
                if (last) begin
                    // carry_q here is the carry into the MSB, fa_co the carry out of it.
                    sum_d   = {fa_s, r_q[WIDTH-1:1]};
                    c_out_d = fa_co;
                    ovf_d   = carry_q ^ fa_co;
                    cnt_d   = '0;
                    state_d = S_DONE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            a_sh_q  <= '0;
            b_sh_q  <= '0;
            r_q     <= '0;
            sum_q   <= '0;
            cnt_q   <= '0;
            carry_q <= 1'b0;
            c_out_q <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            a_sh_q  <= a_sh_d;
            b_sh_q  <= b_sh_d;
            r_q     <= r_d;
            sum_q   <= sum_d;
            cnt_q   <= cnt_d;
            carry_q <= carry_d;
            c_out_q <= c_out_d;
            ovf_q   <= ovf_d;
        end
    end

    assign bus.busy  = (state_q == S_RUN);
    assign bus.done  = (state_q == S_DONE);
    assign bus.sum   = sum_q;
    assign bus.c_out = c_out_q;
    assign bus.ovf   = ovf_q;
endmodule

// File: tb/tb_serial_adder.sv
// Bench for serial_adder: directed table at WIDTH=8, handshake/reset sequences,
// random 8-bit traffic and an exhaustive WIDTH=3 sweep against an arithmetic model.
module tb_serial_adder;
    logic clk;
    logic rst_n;

    serial_adder_if #(.WIDTH(8)) bus8 ();
    serial_adder_if #(.WIDTH(3)) bus3 ();

    serial_adder #(.WIDTH(8)) dut8 (.clk(clk), .rst_n(rst_n), .bus(bus8));
    serial_adder #(.WIDTH(3)) dut3 (.clk(clk), .rst_n(rst_n), .bus(bus3));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_vec = 0;
    int n_bad = 0;

    typedef struct {
        logic       sb;
        logic [7:0] a;
        logic [7:0] b;
        logic       ci;
        logic [7:0] es;
        logic       eco;
        logic       eov;
        bit         b2b;
    } vec_t;

    vec_t tbl[5];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Result packed as {c_out, ovf, sum[7:0]}, computed from signed/unsigned arithmetic.
    function automatic logic [9:0] model(input int w, input logic sb, input logic [7:0] a,
                                         input logic [7:0] b, input logic ci);
        int mask, half, ua, ub, sa, sbv, full, sres;
        logic [7:0] s;
        logic co, ov;
        mask = (1 << w) - 1;
        half = 1 << (w - 1);
        ua   = int'(a) & mask;
        ub   = int'(b) & mask;
        sa   = (ua >= half) ? ua - (1 << w) : ua;
        sbv  = (ub >= half) ? ub - (1 << w) : ub;
        if (!sb) begin
            full = ua + ub + int'(ci);
            co   = ((full >> w) & 1) != 0;
            sres = sa + sbv + int'(ci);
        end else begin
            full = ua - ub;
            co   = (ua >= ub);
            sres = sa - sbv;
        end
        s  = 8'(full & mask);
        ov = (sres > half - 1) || (sres < -half);
        return {co, ov, s};
    endfunction

    task automatic drive(input int w, input logic st, input logic sb, input logic [7:0] a,
                         input logic [7:0] b, input logic ci);
        if (w == 8) begin
            bus8.start = st; bus8.sub = sb; bus8.a = a; bus8.b = b; bus8.c_in = ci;
        end else begin
            bus3.start = st; bus3.sub = sb; bus3.a = a[2:0]; bus3.b = b[2:0]; bus3.c_in = ci;
        end
    endtask

    // {busy, done, c_out, ovf, sum[7:0]}
    function automatic logic [11:0] outs(input int w);
        if (w == 8) return {bus8.busy, bus8.done, bus8.c_out, bus8.ovf, bus8.sum};
        return {bus3.busy, bus3.done, bus3.c_out, bus3.ovf, 5'b0, bus3.sum};
    endfunction

    // Called at a negedge; returns at the negedge where done is seen. Operands are
    // scrambled every cycle after acceptance; at cycle 'disturb' a stray start is raised.
    task automatic run_op(input int w, input logic sb, input logic [7:0] a, input logic [7:0] b,
                          input logic ci, input int disturb, output logic [9:0] res,
                          output int lat, output int nbusy, output bit clean);
        logic [11:0] o;
        logic [9:0]  prev;
        bit          got;
        o     = outs(w);
        prev  = o[9:0];
        res   = '0;
        lat   = -1;
        nbusy = 0;
        clean = 1'b1;
        got   = 1'b0;
        drive(w, 1'b1, sb, a, b, ci);
        for (int c = 1; c <= 2 * w + 8 && !got; c++) begin
            @(negedge clk);
            drive(w, c == disturb, 1'($urandom), 8'($urandom), 8'($urandom), 1'($urandom));
            o = outs(w);
            if (o[11]) nbusy++;
            if (o[11] && o[10]) clean = 1'b0;
            if (o[10]) begin
                got = 1'b1;
                lat = c;
                res = o[9:0];
            end else if (o[9:0] !== prev) begin
                clean = 1'b0;
            end
        end
    endtask

    task automatic idle(input int n);
        drive(8, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0);
        drive(3, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            if (i == 0) chk("idle_busy_done_low", 32'(outs(8) >> 10), 32'd0);
        end
    endtask

    task automatic check_op(input string nm, input int w, input logic [9:0] res,
                            input logic [9:0] exp, input int lat, input int nbusy, input bit clean);
        chk({nm, "_result"}, 32'(res), 32'(exp));
        chk({nm, "_latency"}, 32'(lat), 32'(w + 1));
        chk({nm, "_busy_cycles"}, 32'(nbusy), 32'(w));
        chk({nm, "_clean"}, 32'(clean), 32'd1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [9:0] res;
        int         lat, nbusy;
        bit         clean, seen;
        logic       sb, ci;
        logic [7:0] a, b;

        tbl[0] = '{1'b0, 8'h0F, 8'h01, 1'b0, 8'h10, 1'b0, 1'b0, 1'b0};
        tbl[1] = '{1'b0, 8'hFF, 8'h01, 1'b1, 8'h01, 1'b1, 1'b0, 1'b0};
        tbl[2] = '{1'b0, 8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1, 1'b1};
        tbl[3] = '{1'b1, 8'h05, 8'h07, 1'b1, 8'hFE, 1'b0, 1'b0, 1'b0};
        tbl[4] = '{1'b1, 8'h80, 8'h01, 1'b0, 8'h7F, 1'b1, 1'b1, 1'b1};

        rst_n = 1'b0;
        drive(8, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0);
        drive(3, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0);
        repeat (3) @(negedge clk);
        chk("reset_outs_w8", 32'(outs(8)), 32'd0);
        chk("reset_outs_w3", 32'(outs(3)), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 5; i++) begin
            if (!tbl[i].b2b) idle(2);
            run_op(8, tbl[i].sb, tbl[i].a, tbl[i].b, tbl[i].ci, 0, res, lat, nbusy, clean);
            check_op($sformatf("table%0d", i), 8, res, {tbl[i].eco, tbl[i].eov, tbl[i].es},
                     lat, nbusy, clean);
        end

        // Stray start three cycles into RUN must not disturb the running operation.
        idle(2);
        run_op(8, 1'b0, 8'h3C, 8'h11, 1'b1, 3, res, lat, nbusy, clean);
        check_op("ignored_start", 8, res, {1'b0, 1'b0, 8'h4E}, lat, nbusy, clean);

        // Reset in the middle of RUN aborts without a done pulse.
        idle(2);
        drive(8, 1'b1, 1'b0, 8'hA5, 8'h3C, 1'b0);
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            drive(8, 1'b0, 1'b0, 8'hA5, 8'h3C, 1'b0);
        end
        rst_n = 1'b0;
        #1;
        chk("abort_outs_zero", 32'(outs(8)), 32'd0);
        seen = 1'b0;
        repeat (3) begin
            @(negedge clk);
            if (outs(8) != 12'd0) seen = 1'b1;
        end
        chk("abort_no_done", 32'(seen), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        run_op(8, 1'b0, 8'h01, 8'h01, 1'b0, 0, res, lat, nbusy, clean);
        check_op("after_reset", 8, res, {1'b0, 1'b0, 8'h02}, lat, nbusy, clean);

        for (int i = 0; i < 40; i++) begin
            sb = 1'($urandom);
            ci = 1'($urandom);
            a  = 8'($urandom);
            b  = 8'($urandom);
            if ($urandom_range(0, 1) == 0) idle(1);
            run_op(8, sb, a, b, ci, 0, res, lat, nbusy, clean);
            chk($sformatf("rand%0d_result", i), 32'(res), 32'(model(8, sb, a, b, ci)));
            chk($sformatf("rand%0d_latency", i), 32'(lat), 32'd9);
        end

        idle(1);
        for (int s = 0; s < 2; s++)
            for (int c = 0; c < 2; c++)
                for (int x = 0; x < 8; x++)
                    for (int y = 0; y < 8; y++) begin
                        run_op(3, 1'(s), 8'(x), 8'(y), 1'(c), 0, res, lat, nbusy, clean);
                        chk($sformatf("w3_s%0d_c%0d_%0d_%0d_result", s, c, x, y), 32'(res),
                            32'(model(3, 1'(s), 8'(x), 8'(y), 1'(c))));
                        chk($sformatf("w3_s%0d_c%0d_%0d_%0d_latency", s, c, x, y), 32'(lat), 32'd4);
                    end

        idle(2);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule

// File: doc/serial_adder.md
# serial_adder

Parametrised bit-serial adder/subtractor that processes two WIDTH-bit operands one bit per clock through a single full-adder slice. It extends the combinational one-bit full adder into a multi-cycle arithmetic unit with a start/busy/done handshake, a subtract mode and signed-overflow detection. It serves area-constrained datapaths where latency is acceptable.

## Interface
- WIDTH, 8, operand and result width in bits; legal range 2..32.
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  one-cycle request; accepted only in IDLE or DONE.
- sub  input  1  0 = add (a + b + c_in); 1 = subtract (a - b, with c_in ignored).
- a  input  WIDTH  operand A, sampled on the accepting edge only.
- b  input  WIDTH  operand B, sampled on the accepting edge only.
- c_in  input  1  carry-in for add, sampled with a and b.
- busy  output  1  high while in RUN.
- done  output  1  one-cycle pulse when the result is valid.
- sum  output  WIDTH  result, held from done until the next completion.
- c_out  output  1  carry out of the MSB; in subtract mode 1 = no borrow.
- ovf  output  1  two's-complement signed overflow.

## Operation
- States: IDLE, RUN, DONE. Reset enters IDLE.
- Accepting edge (start=1 in IDLE or DONE):
  - Latch a into shift register A.
  - Latch b (add) or ~b (sub) into shift register B.
  - Initial carry = c_in (add) or 1 (sub).
  - Bit counter = 0; go to RUN.
- RUN, each edge:
  - Full adder on A[0], B[0], carry.
  - Shift the sum bit into the MSB end of result register R.
  - Shift A and B right; register carry-out into carry.
  - Counter increments.
- On the edge that processes bit WIDTH-1:
  - Copy R (with final bit) to sum.
  - c_out = final carry.
  - ovf = carry into MSB XOR carry out of MSB (capture carry-in at bit WIDTH-1).
  - Go to DONE.
- DONE lasts one cycle (done=1). Next edge goes to IDLE, or to RUN if start=1.
- start while in RUN is ignored: no queueing, no effect on the operation in progress.
- sum, c_out and ovf change only on the completing edge. Intermediate shift state never appears on the outputs.
- Arithmetic is modulo 2^WIDTH. Wrap-around is reported only through c_out and ovf.

## Timing
- Reset (async assert, sync-safe release): state=IDLE, busy=0, done=0, sum=0, c_out=0, ovf=0, counter=0, internal shift registers=0.
- Latency: accepting edge E0; bits processed on edges E1..E_WIDTH.
  - busy is high for the WIDTH cycles after E0.
  - done is high for exactly one cycle after E_WIDTH.
  - Result is valid WIDTH+1 cycles after start is sampled.
- Back-to-back: start held high in DONE is accepted. Throughput is one result per WIDTH+1 cycles.
- busy and done are never high together.
- Reset asserted mid-RUN aborts immediately:
  - All outputs return to reset values.
  - No done pulse is produced for the aborted operation.
- a, b, c_in and sub may change freely after the accepting edge without affecting the result.

## Test plan
- WIDTH=8, add, a=8'h0F, b=8'h01, c_in=0 -> sum=8'h10, c_out=0, ovf=0. done high exactly 9 cycles after start sampled; busy high for 8 cycles.
- WIDTH=8, add, a=8'hFF, b=8'h01, c_in=1 -> sum=8'h01, c_out=1, ovf=0. Then a=8'h7F, b=8'h01, c_in=0 back-to-back -> sum=8'h80, c_out=0, ovf=1.
- WIDTH=8, sub, a=8'h05, b=8'h07, c_in=1 -> sum=8'hFE, c_out=0, ovf=0 (c_in ignored). Then a=8'h80, b=8'h01 -> sum=8'h7F, c_out=1, ovf=1.
- Handshake: pulse start again 3 cycles into RUN with different operands -> ignored; the original result is delivered on schedule. Operand inputs changed mid-RUN -> no effect.
- Reset: assert rst_n=0 at cycle 4 of RUN -> outputs all 0, no done. After release, start with a=8'h01, b=8'h01 -> sum=8'h02.
- WIDTH=3, exhaustive sweep of all a, b, c_in, sub (256 cases) against a behavioural model. sum, c_out and ovf must match in every case, with done after 4 cycles.
